// File: rtl/moore_seq_sequencer.sv
// Moore sequencer stepping a state index in WRAP, BOUNCE or ONESHOT mode; MOORE_SEQ_DWELL_EN adds a per-state dwell counter.
// Latency: a step sampled at edge k shows on every output after edge k; outputs depend on registers only.
// Backpressure: none; en gates advance and load overrides en.
module moore_seq_sequencer #(
    parameter int  NUM_STATES = 3,
    parameter int  DWELL      = 0,
    localparam int STATE_W    = $clog2(NUM_STATES)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  dir,
    input  logic [1:0]            mode,
    input  logic                  load,
    input  logic [STATE_W-1:0]    load_val,
    output logic [STATE_W-1:0]    state_out,
    output logic [NUM_STATES-1:0] onehot_out,
    output logic                  at_first,
    output logic                  at_last,
    output logic                  wrap_pulse,
    output logic                  done
);

    localparam logic [STATE_W-1:0] LAST         = STATE_W'(NUM_STATES - 1);
    localparam logic [STATE_W-1:0] ONE          = STATE_W'(1);
    localparam logic [1:0]         MODE_BOUNCE  = 2'b01;
    localparam logic [1:0]         MODE_ONESHOT = 2'b10;

    if (NUM_STATES < 2 || NUM_STATES > 256) begin : g_bad_num_states
        $error("moore_seq_sequencer: NUM_STATES must be 2..256");
    end
    if (DWELL < 0 || DWELL > 255) begin : g_bad_dwell
        $error("moore_seq_sequencer: DWELL must be 0..255");
    end

    logic [STATE_W-1:0] state_q, state_d;
    logic               bdir_q, bdir_d;
    logic               wrap_q, wrap_d;
    logic               done_q, done_d;
    logic               step;
`ifdef MOORE_SEQ_DWELL_EN
    logic [7:0]         dwell_q, dwell_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= '0;
            bdir_q  <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MOORE_SEQ_DWELL_EN
            dwell_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            bdir_q  <= bdir_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
`ifdef MOORE_SEQ_DWELL_EN
            dwell_q <= dwell_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        // Leaving BOUNCE re-arms upward travel so the next BOUNCE entry starts up.
        bdir_d  = (mode == MODE_BOUNCE) ? bdir_q : 1'b0;
        wrap_d  = 1'b0;
        done_d  = done_q;
        step    = 1'b0;
`ifdef MOORE_SEQ_DWELL_EN
        dwell_d = dwell_q;
        if (load) begin
            dwell_d = '0;
        end else if (en) begin
            if (dwell_q == 8'(DWELL)) begin
                dwell_d = '0;
                step    = 1'b1;
            end else begin
                dwell_d = dwell_q + 8'd1;
            end
        end
`else
        step = en && !load;
`endif
        if (load) begin
            state_d = (load_val > LAST) ? LAST : load_val;
            done_d  = 1'b0;
        end else if (step) begin
            case (mode)
                MODE_BOUNCE: begin
                    if (!bdir_q) begin
                        if (state_q == LAST) begin
                            state_d = LAST - ONE;
                            bdir_d  = 1'b1;
                            wrap_d  = 1'b1;
                        end else begin
                            state_d = state_q + ONE;
                        end
                    end else begin
                        if (state_q == '0) begin
                            state_d = ONE;
                            bdir_d  = 1'b0;
                            wrap_d  = 1'b1;
                        end else begin
                            state_d = state_q - ONE;
                        end
                    end
                end
                MODE_ONESHOT: begin
                    if (!dir && state_q != LAST) state_d = state_q + ONE;
                    if (dir && state_q != '0)    state_d = state_q - ONE;
                    done_d = done_q | (dir ? (state_d == '0) : (state_d == LAST));
                end
                default: begin
                    if (!dir) begin
                        wrap_d  = (state_q == LAST);
                        state_d = (state_q == LAST) ? '0 : state_q + ONE;
                    end else begin
                        wrap_d  = (state_q == '0);
                        state_d = (state_q == '0) ? LAST : state_q - ONE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        state_out  = state_q;
        onehot_out = NUM_STATES'(1) << state_q;
        at_first   = (state_q == '0);
        at_last    = (state_q == LAST);
        wrap_pulse = wrap_q;
        done       = done_q;
    end

endmodule

// File: tb/tb_moore_seq_sequencer.sv
// Bench for moore_seq_sequencer: five instances (N = 2,3,4,5,8) share stimulus; table vectors, random run against a model, async reset check.
`timescale 1ns/1ps
module tb_moore_seq_sequencer;

    localparam int NDUT = 5;
    localparam int DW   = 2;
`ifdef MOORE_SEQ_DWELL_EN
    localparam int STEP_CYC = DW + 1;
`else
    localparam int STEP_CYC = 1;
`endif

    function automatic int ns_of(input int i);
        case (i)
            0: return 2;
            1: return 3;
            2: return 4;
            3: return 5;
            default: return 8;
        endcase
    endfunction

    logic       clk = 1'b0;
    logic       reset_n, en, dir, load;
    logic [1:0] mode;
    logic [7:0] load_val;

    wire [7:0]  st_a [NDUT];
    wire [15:0] oh_a [NDUT];
    wire        af_a [NDUT];
    wire        al_a [NDUT];
    wire        wp_a [NDUT];
    wire        dn_a [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int N = ns_of(g);
        localparam int W = $clog2(N);
        logic [W-1:0] st;
        logic [N-1:0] oh;
        logic         af, al, wp, dn;
        moore_seq_sequencer #(.NUM_STATES(N), .DWELL(DW)) u_dut (
            .clk(clk), .reset_n(reset_n), .en(en), .dir(dir), .mode(mode),
            .load(load), .load_val(load_val[W-1:0]), .state_out(st),
            .onehot_out(oh), .at_first(af), .at_last(al), .wrap_pulse(wp), .done(dn)
        );
        assign st_a[g] = 8'(st);
        assign oh_a[g] = 16'(oh);
        assign af_a[g] = af;
        assign al_a[g] = al;
        assign wp_a[g] = wp;
        assign dn_a[g] = dn;
    end

    // Reference model: position plus a +1/-1 travel direction for bounce.
    int m_pos [NDUT], m_d [NDUT], m_wrap [NDUT], m_done [NDUT], m_cnt [NDUT];
    int nvec = 0;
    int nbad = 0;

    task automatic model_reset();
        for (int i = 0; i < NDUT; i++) begin
            m_pos[i] = 0; m_d[i] = 1; m_wrap[i] = 0; m_done[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < NDUT; i++) begin
            int n, lv, tgt;
            bit stp;
            n   = ns_of(i);
            lv  = int'(load_val) & ((1 << $clog2(n)) - 1);
            stp = 0;
            m_wrap[i] = 0;
            if (load) begin
                m_pos[i]  = (lv > n - 1) ? n - 1 : lv;
                m_done[i] = 0;
                m_cnt[i]  = 0;
            end else if (en) begin
`ifdef MOORE_SEQ_DWELL_EN
                if (m_cnt[i] == DW) begin m_cnt[i] = 0; stp = 1; end
                else m_cnt[i]++;
`else
                stp = 1;
`endif
            end
            if (stp) begin
                case (mode)
                    2'b01: begin
                        if (m_pos[i] + m_d[i] < 0 || m_pos[i] + m_d[i] > n - 1) begin
                            m_d[i] = -m_d[i];
                            m_wrap[i] = 1;
                        end
                        m_pos[i] += m_d[i];
                    end
                    2'b10: begin
                        tgt = dir ? 0 : n - 1;
                        if (m_pos[i] != tgt) m_pos[i] += dir ? -1 : 1;
                        if (m_pos[i] == tgt) m_done[i] = 1;
                    end
                    default: begin
                        if ((dir && m_pos[i] == 0) || (!dir && m_pos[i] == n - 1)) m_wrap[i] = 1;
                        m_pos[i] = (m_pos[i] + (dir ? n - 1 : 1)) % n;
                    end
                endcase
            end
            if (mode != 2'b01) m_d[i] = 1;
        end
    endtask

    task automatic chk(input string nm, input int i, input logic [15:0] got, input logic [15:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s dut%0d(N=%0d) got %0d expected %0d at %0t", nm, i, ns_of(i), got, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NDUT; i++) begin
            chk("state", i, 16'(st_a[i]), 16'(m_pos[i]));
            chk("onehot", i, oh_a[i], 16'(1 << m_pos[i]));
            chk("at_first", i, 16'(af_a[i]), 16'(m_pos[i] == 0));
            chk("at_last", i, 16'(al_a[i]), 16'(m_pos[i] == ns_of(i) - 1));
            chk("wrap_pulse", i, 16'(wp_a[i]), 16'(m_wrap[i]));
            chk("done", i, 16'(dn_a[i]), 16'(m_done[i]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    typedef struct {
        logic       en, dir;
        logic [1:0] mode;
        logic       load;
        logic [7:0] lv;
        int         dut, st;
        logic       wp, dn;
    } vec_t;
    vec_t tbl [$];

    function automatic void add(input logic e, input logic d, input logic [1:0] m, input logic l,
                                input logic [7:0] v, input int du, input int s, input logic w, input logic dn);
        vec_t r;
        r.en = e; r.dir = d; r.mode = m; r.load = l; r.lv = v;
        r.dut = du; r.st = s; r.wp = w; r.dn = dn;
        tbl.push_back(r);
    endfunction

    initial begin
        int exp_wrap [7] = '{1, 2, 0, 1, 2, 0, 1};
        int exp_bst [9]  = '{1, 2, 3, 4, 3, 2, 1, 0, 1};
        int exp_bwp [9]  = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
        for (int k = 0; k < 7; k++) add(1, 0, 2'b00, 0, 8'd0, 1, exp_wrap[k], exp_wrap[k] == 0, 0);
        add(0, 0, 2'b01, 1, 8'd0, 3, 0, 0, 0);
        for (int k = 0; k < 9; k++) add(1, 0, 2'b01, 0, 8'd0, 3, exp_bst[k], exp_bwp[k][0], 0);
        add(0, 1, 2'b10, 1, 8'd2, 2, 2, 0, 0);
        add(1, 1, 2'b10, 0, 8'd0, 2, 1, 0, 0);
        add(1, 1, 2'b10, 0, 8'd0, 2, 0, 0, 1);
        add(1, 1, 2'b10, 0, 8'd0, 2, 0, 0, 1);
        add(1, 1, 2'b10, 0, 8'd0, 2, 0, 0, 1);
        add(0, 1, 2'b10, 1, 8'd3, 2, 3, 0, 0);
        add(0, 0, 2'b00, 1, 8'd7, 3, 4, 0, 0);
        add(1, 0, 2'b00, 1, 8'd1, 3, 1, 0, 0);
        add(1, 0, 2'b00, 0, 8'd0, 3, 2, 0, 0);
        add(0, 0, 2'b01, 1, 8'd0, 0, 0, 0, 0);
        add(1, 0, 2'b01, 0, 8'd0, 0, 1, 0, 0);
        add(1, 0, 2'b01, 0, 8'd0, 0, 0, 1, 0);
        add(1, 0, 2'b01, 0, 8'd0, 0, 1, 1, 0);
        add(1, 0, 2'b01, 0, 8'd0, 0, 0, 1, 0);

        reset_n = 1'b0; en = 1'b0; dir = 1'b0; mode = 2'b00; load = 1'b0; load_val = 8'd0;
        model_reset();
        @(negedge clk);
        check_all();
        reset_n = 1'b1;

`ifndef MOORE_SEQ_DWELL_EN
        foreach (tbl[r]) begin
            en = tbl[r].en; dir = tbl[r].dir; mode = tbl[r].mode;
            load = tbl[r].load; load_val = tbl[r].lv;
            tick();
            chk("tbl_state", tbl[r].dut, 16'(st_a[tbl[r].dut]), 16'(tbl[r].st));
            chk("tbl_wrap", tbl[r].dut, 16'(wp_a[tbl[r].dut]), 16'(tbl[r].wp));
            chk("tbl_done", tbl[r].dut, 16'(dn_a[tbl[r].dut]), 16'(tbl[r].dn));
        end
`else
        en = 1'b1; dir = 1'b0; mode = 2'b00; load = 1'b0;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk("dwell_state", 1, 16'(st_a[1]), 16'(((k + 1) / (DW + 1)) % 3));
        end
        tick();
        en = 1'b0;
        tick();
        tick();
        chk("dwell_hold", 1, 16'(st_a[1]), 16'd0);
        en = 1'b1;
        tick();
        chk("dwell_resume", 1, 16'(st_a[1]), 16'd0);
        tick();
        chk("dwell_step", 1, 16'(st_a[1]), 16'd1);
`endif

        for (int k = 0; k < 800; k++) begin
            en       = ($urandom_range(3) != 0);
            dir      = 1'($urandom_range(1));
            mode     = 2'($urandom_range(3));
            load     = ($urandom_range(7) == 0);
            load_val = 8'($urandom);
            tick();
        end

        en = 1'b0; dir = 1'b0; mode = 2'b10; load = 1'b1; load_val = 8'd0;
        tick();
        load = 1'b0; en = 1'b1;
        repeat (2 * STEP_CYC) tick();
        chk("pre_reset_state", 1, 16'(st_a[1]), 16'd2);
        chk("pre_reset_done", 1, 16'(dn_a[1]), 16'd1);
        en = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            chk("rst_state", i, 16'(st_a[i]), 16'd0);
            chk("rst_onehot", i, oh_a[i], 16'd1);
            chk("rst_at_first", i, 16'(af_a[i]), 16'd1);
            chk("rst_at_last", i, 16'(al_a[i]), 16'd0);
            chk("rst_wrap", i, 16'(wp_a[i]), 16'd0);
            chk("rst_done", i, 16'(dn_a[i]), 16'd0);
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        en = 1'b1; mode = 2'b00;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
